rgb_to_phase: RTL and testbench

RGB_TO_PHASE -- requirements
Module: rgb_to_phase

---
 rtl/phase_pkg.sv | 29 ++
 rtl/hue_divider.sv | 57 +++++
 rtl/rgb_to_phase.sv | 120 ++++++++++++
 tb/tb_rgb_to_phase.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared constants and types for the RGB hue-to-phase converter.
package phase_pkg;

  localparam logic signed [15:0] PI_Q_DEF        = 16'sd25736;
  localparam logic [15:0]        PHASE_SCALE_DEF = 16'd34315;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } sector_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_DIV,
    ST_MAP,
    ST_DONE
  } state_t;

  // Even sectors ramp the hue up across the sector, odd ones ramp it down.
  function automatic logic is_rising(input sector_t s);
    return ~s[0];
  endfunction

endpackage

// File: rtl/hue_divider.sv
// 8-step restoring divider. It produces one quotient bit per cycle, MSB first.
// The caller guarantees that the quotient fits in 8 bits.
module hue_divider
  import phase_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        done,
  output logic [7:0]  quotient
);

  logic [7:0] rem;
  logic [7:0] lo;
  logic [7:0] dvs;
  logic [2:0] cnt;
  logic       busy;
  logic [8:0] trial;
  logic [8:0] diff;

  assign trial = {rem, lo[7]};
  assign diff  = trial - {1'b0, dvs};
  assign done  = busy && (cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      lo       <= '0;
      dvs      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      // The upper byte is already below the divisor because q < 256.
      rem      <= dividend[15:8];
      lo       <= dividend[7:0];
      dvs      <= divisor;
      cnt      <= '0;
      busy     <= 1'b1;
      quotient <= '0;
    end else if (busy) begin
      if (trial >= {1'b0, dvs}) begin
        rem      <= diff[7:0];
        quotient <= {quotient[6:0], 1'b1};
      end else begin
        rem      <= trial[7:0];
        quotient <= {quotient[6:0], 1'b0};
      end
      lo   <= {lo[6:0], 1'b0};
      cnt  <= cnt + 3'd1;
      busy <= (cnt != 3'd7);
    end
  end

endmodule

// File: rtl/rgb_to_phase.sv
// This block converts an RGB sample to a hue index and then to a signed phase code.
// Each sample takes a fixed 10-cycle trip through the FSM.
module rgb_to_phase
  import phase_pkg::*;
#(
  parameter logic signed [15:0] PI_Q        = PI_Q_DEF,
  parameter logic [15:0]        PHASE_SCALE = PHASE_SCALE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         r,
  input  logic [7:0]         g,
  input  logic [7:0]         b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] phase,
  output logic [10:0]        hue_idx,
  output logic               gray
);

  state_t      state, state_nx;
  logic [7:0]  r_q, g_q, b_q;
  sector_t     sector_c, sector_q;
  logic [7:0]  max_c, mid_c, min_c, delta_c;
  logic [15:0] dividend_c;
  logic        gray_q, rising_q;
  logic        div_done;
  logic [7:0]  q;
  logic [7:0]  q_eff;
  logic [10:0] hue_c;
  logic [25:0] prod;
  logic [15:0] phase_c;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (in_valid)  state_nx = ST_CLASSIFY;
      ST_CLASSIFY: state_nx = ST_DIV;
      ST_DIV:      if (div_done)  state_nx = ST_MAP;
      ST_MAP:      state_nx = ST_DONE;
      ST_DONE:     if (out_ready) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Sector priority order resolves ties. A gray input falls into S0 with delta 0.
  always_comb begin
    sector_c = S5;
    max_c    = r_q;
    mid_c    = b_q;
    min_c    = g_q;
    if (r_q >= g_q && g_q >= b_q) begin
      sector_c = S0; max_c = r_q; mid_c = g_q; min_c = b_q;
    end else if (g_q > r_q && r_q >= b_q) begin
      sector_c = S1; max_c = g_q; mid_c = r_q; min_c = b_q;
    end else if (g_q >= b_q && b_q > r_q) begin
      sector_c = S2; max_c = g_q; mid_c = b_q; min_c = r_q;
    end else if (b_q > g_q && g_q >= r_q) begin
      sector_c = S3; max_c = b_q; mid_c = g_q; min_c = r_q;
    end else if (b_q >= r_q && r_q > g_q) begin
      sector_c = S4; max_c = b_q; mid_c = r_q; min_c = g_q;
    end
    delta_c    = max_c - min_c;
    dividend_c = {8'd0, mid_c - min_c} * 16'd255;
  end

  hue_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (state == ST_CLASSIFY),
    .dividend (dividend_c),
    .divisor  (delta_c),
    .done     (div_done),
    .quotient (q)
  );

  // ~q equals 255-q for an 8-bit value.
  assign q_eff   = rising_q ? q : ~q;
  assign hue_c   = gray_q ? 11'd0 : {sector_q, q_eff};
  assign prod    = 26'(hue_c) * 26'(PHASE_SCALE);
  assign phase_c = 16'(prod >> 10) - PI_Q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      sector_q <= S0;
      rising_q <= 1'b0;
      gray_q   <= 1'b0;
      phase    <= '0;
      hue_idx  <= '0;
      gray     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && in_valid) begin
        r_q <= r;
        g_q <= g;
        b_q <= b;
      end
      if (state == ST_CLASSIFY) begin
        sector_q <= sector_c;
        rising_q <= is_rising(sector_c);
        gray_q   <= (delta_c == 8'd0);
      end
      if (state == ST_MAP) begin
        hue_idx <= hue_c;
        phase   <= signed'(phase_c);
        gray    <= gray_q;
      end
    end
  end

endmodule

// File: tb/tb_rgb_to_phase.sv
// This bench drives rgb_to_phase with directed vectors and checks hand-computed
// hue and phase values, latency, handshake and reset behaviour.
module tb_rgb_to_phase;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         r, g, b;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] phase;
  logic [10:0]        hue_idx;
  logic               gray;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rgb_to_phase dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r         (r),
    .g         (g),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .phase     (phase),
    .hue_idx   (hue_idx),
    .gray      (gray)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In noisy mode, in_valid and out_ready stay high while the sample is in flight.
  // The DUT must ignore both until the proper state.
  task automatic run_sample(input string tag, input logic [7:0] rr, gg, bb,
                            input int eh, input int ep, input logic eg,
                            input bit noisy);
    int early = 0;
    chk({tag, "/in_ready_idle"}, in_ready, 1);
    r = rr; g = gg; b = bb; in_valid = 1'b1;
    tick();
    if (noisy) begin
      r = 8'd0; g = 8'd0; b = 8'd255; out_ready = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    if (out_valid !== 1'b0) early++;
    for (int k = 1; k < 10; k++) begin
      tick();
      if (out_valid !== 1'b0) early++;
    end
    chk({tag, "/early_valid"}, early, 0);
    tick();
    chk({tag, "/out_valid"}, out_valid, 1);
    chk({tag, "/hue_idx"}, hue_idx, eh);
    chk({tag, "/phase"}, phase, ep);
    chk({tag, "/gray"}, gray, eg);
    chk({tag, "/in_ready_busy"}, in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "/valid_drop"}, out_valid, 0);
    chk({tag, "/in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    r = '0; g = '0; b = '0;
    tick();
    tick();
    chk("rst/out_valid", out_valid, 0);
    chk("rst/phase", phase, 0);
    chk("rst/hue_idx", hue_idx, 0);
    chk("rst/gray", gray, 0);
    chk("rst/in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    run_sample("red",     8'd255, 8'd0,   8'd0,   0,    -25736, 1'b0, 1'b0);
    run_sample("s0_mid",  8'd200, 8'd100, 8'd50,  85,   -22888, 1'b0, 1'b0);
    run_sample("cyan",    8'd0,   8'd255, 8'd255, 767,  -34,    1'b0, 1'b1);
    run_sample("s5_edge", 8'd255, 8'd0,   8'd1,   1534, 25669,  1'b0, 1'b0);
    run_sample("gray",    8'd100, 8'd100, 8'd100, 0,    -25736, 1'b1, 1'b0);
    run_sample("green",   8'd0,   8'd255, 8'd0,   511,  -8613,  1'b0, 1'b1);
    run_sample("blue",    8'd0,   8'd0,   8'd255, 1023, 8545,   1'b0, 1'b0);
    run_sample("magenta", 8'd255, 8'd0,   8'd255, 1279, 17124,  1'b0, 1'b0);

    // Keep the result in DONE with out_ready low. The outputs must not change.
    r = 8'd200; g = 8'd100; b = 8'd50; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || hue_idx !== 11'd85 ||
          phase !== -16'sd22888 || gray !== 1'b0) cnt++;
      tick();
    end
    chk("hold/stable", cnt, 0);
    chk("hold/still_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold/released", in_ready, 1);

    // Reset during DIV aborts the sample.
    r = 8'd255; g = 8'd0; b = 8'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("abort/busy", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort/in_ready", in_ready, 1);
    chk("abort/hue_cleared", hue_idx, 0);
    chk("abort/phase_cleared", phase, 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid !== 1'b0) cnt++;
      tick();
    end
    chk("abort/no_output", cnt, 0);

    run_sample("recover", 8'd200, 8'd100, 8'd50, 85, -22888, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
